sram_controller: RTL
====================

// Module: sram_controller
// PURPOSE
//  Bus-side responder for the on-board asynchronous SRAM (BaseRAM/ExtRAM): accepts
//  single-word read/write requests from the CPU memory stage and sequences the external
//  SRAM pins with fixed, parameterised timing. Sits between the bus mux and the SRAM pad
//  tristate; runs on clk_ram (100 MHz). It is the device the sram unit test drives.
// PARAMETERS
//  RD_CYCLES   2   cycles CE_n/OE_n held low before read data is sampled (>=1)
//  WR_CYCLES   2   cycles WE_n held low per write (>=1)
// PORTS
//  clk          in   1   clk_ram, all logic on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  req          in   1   request valid; held by requester until ack
//  we           in   1   1 = write, 0 = read; stable while req
//  addr         in   20  word address
//  wdata        in   32  write data
//  be           in   4   byte enables, active high; be[0] = bits 7:0
//  ack          out  1   one-cycle completion pulse
//  rdata        out  32  read data, valid with ack and held until next read completes
//  ram_addr     out  20  SRAM address pins
//  ram_data_i   in   32  SRAM data pins, input side
//  ram_data_o   out  32  SRAM data pins, output side
//  ram_data_oe  out  1   1 = controller drives ram_data (tristate enable at top level)
//  ram_ce_n     out  1   chip enable, active low
//  ram_oe_n     out  1   output enable, active low
//  ram_we_n     out  1   write enable, active low
//  ram_be_n     out  4   byte enables, active low
// BEHAVIOUR
//  - Reset: ack=0, rdata=0, ram_addr=0, ram_data_o=0, ram_data_oe=0, ram_ce_n=1,
//    ram_oe_n=1, ram_we_n=1, ram_be_n=4'hF; FSM=IDLE; timer counter=0. All SRAM outputs
//    are registered, so there are no pin glitches.
//  - FSM states: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
//  - IDLE: req & !we -> latch addr, set ce_n=0, oe_n=0, be_n=0, load counter=RD_CYCLES-1,
//    go to READ. req & we -> latch addr, wdata and ~be; set data_oe=1, ce_n=0, we_n=1,
//    oe_n=1; go to WR_SETUP.
//  - READ: decrement counter. When counter==0, sample ram_data_i into rdata, set ce_n and
//    oe_n to 1, go to DONE.
//  - WR_SETUP: 1 cycle of address/data setup. Set we_n=0, load counter=WR_CYCLES-1,
//    go to WR_PULSE.
//  - WR_PULSE: decrement counter. When counter==0, set we_n=1 and go to WR_HOLD. Data and
//    address stay driven.
//  - WR_HOLD: 1 cycle of hold. Then set ce_n=1, data_oe=0, be_n=F; go to DONE.
//  - DONE: ack=1 for exactly this cycle. req is ignored here because the requester is
//    still holding it. Next state is IDLE.
//  - Latency from the cycle req is sampled in IDLE to ack: read = RD_CYCLES+1 (3 by
//    default); write = WR_CYCLES+3 (5). Minimum gap between back-to-back transactions is
//    one IDLE cycle.
//  - Write with be=0: full pin sequence still runs with be_n=F, so memory is unchanged;
//    ack is still returned.
//  - Changing we, addr or wdata while req is high and before ack is illegal. These inputs
//    are latched at accept, so later changes have no effect.
//  - rst_n asserted mid-transaction: immediate return to reset values. The SRAM is
//    deselected (ce_n=1, we_n=1) asynchronously. No ack is issued for the aborted request.
//  - Never drive ram_data_oe=1 while ram_oe_n=0.
// CONFIGURATION
//  SRAM_CTRL_POSTED_WRITE_EN defined:
//    - Writes are acked in the cycle after accept (the WR_SETUP cycle). The pin sequence
//      then completes unchanged.
//    - DONE after a write produces no ack.
//    - A new req is not sampled until the FSM is back in IDLE.
//    - Read timing is unchanged.
//  SRAM_CTRL_POSTED_WRITE_EN undefined: ack only in DONE, as described above.
// STRUCTURE
//  - Shared package in defines.svh:
//    - Word_t (32b), RamAddr_t (20b), ByteEn_t (4b)
//    - SramState_t enum
//    - SRAM_RD_CYCLES_DEFAULT / SRAM_WR_CYCLES_DEFAULT constants
//  - Single module, no sub-module. The timer is an inline down-counter of
//    $clog2(max(RD_CYCLES,WR_CYCLES)+1) bits. The tristate pad stays in the top level.
// TESTING (bench sram_test_tb with a behavioural async SRAM model, clk 100 MHz, rst_n low 200 ns)
//  1 Reset values: all outputs at reset values; ram_ce_n=1 throughout reset.
//  2 Write/read:
//    - write addr=20'h00010, wdata=32'hDEADBEEF, be=F -> ack 5 cycles after accept;
//      WE_n low for exactly 2 cycles.
//    - read addr=20'h00010 -> ack 3 cycles after accept, rdata=32'hDEADBEEF.
//  3 Byte enables:
//    - write 32'h11223344 to addr 20'h00020, be=F.
//    - write 32'hAABBCCDD to addr 20'h00020, be=4'b0101.
//    - read -> 32'h11BB33DD.
//  4 Back-to-back: 256 writes (addr=i, data=i*32'h01010101), then 256 reads -> all match.
//    - ack is exactly 1 cycle per transaction.
//    - no second accept while req is held in DONE.
//  5 Reset mid-write: drop rst_n in WR_PULSE -> same cycle ram_we_n=1, ram_ce_n=1,
//    ram_data_oe=0; no ack; after release, a read completes normally.
//  6 With SRAM_CTRL_POSTED_WRITE_EN: write -> ack 1 cycle after accept; an immediate
//    following read is accepted only after WR_HOLD and returns the new data.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared types and timing defaults for the asynchronous SRAM controller.
`timescale 1ns/1ps
package sram_controller_pkg;

    localparam int SRAM_RD_CYCLES_DEFAULT = 2;
    localparam int SRAM_WR_CYCLES_DEFAULT = 2;

    typedef logic [31:0] word_t;
    typedef logic [19:0] ram_addr_t;
    typedef logic [3:0]  byte_en_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } sram_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Single-word request/acknowledge bus between the CPU memory stage and the SRAM controller.
`timescale 1ns/1ps
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic      req;
    logic      we;
    ram_addr_t addr;
    word_t     wdata;
    byte_en_t  be;
    logic      ack;
    word_t     rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/sram_controller.sv
// Sequences the external asynchronous SRAM pins for single-word reads and writes.
// Optional macro SRAM_CTRL_POSTED_WRITE_EN: acknowledge writes right after accept.
`timescale 1ns/1ps
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int RD_CYCLES = SRAM_RD_CYCLES_DEFAULT,
    parameter int WR_CYCLES = SRAM_WR_CYCLES_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    sram_controller_if.slave bus,
    output ram_addr_t ram_addr,
    input  word_t     ram_data_i,
    output word_t     ram_data_o,
    output logic      ram_data_oe,
    output logic      ram_ce_n,
    output logic      ram_oe_n,
    output logic      ram_we_n,
    output byte_en_t  ram_be_n
);

    localparam int CNT_W = $clog2(max_int(RD_CYCLES, WR_CYCLES) + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef SRAM_CTRL_POSTED_WRITE_EN
    localparam bit POSTED_WRITE = 1'b1;
`else
    localparam bit POSTED_WRITE = 1'b0;
`endif

    sram_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ack_reg, ack_next;
    word_t            rdata_reg, rdata_next;
    ram_addr_t        addr_reg, addr_next;
    word_t            data_o_reg, data_o_next;
    logic             data_oe_reg, data_oe_next;
    logic             ce_n_reg, ce_n_next;
    logic             oe_n_reg, oe_n_next;
    logic             we_n_reg, we_n_next;
    byte_en_t         be_n_reg, be_n_next;

    // Every pin comes straight from a flop so the SRAM never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ack_reg     <= 1'b0;
            rdata_reg   <= '0;
            addr_reg    <= '0;
            data_o_reg  <= '0;
            data_oe_reg <= 1'b0;
            ce_n_reg    <= 1'b1;
            oe_n_reg    <= 1'b1;
            we_n_reg    <= 1'b1;
            be_n_reg    <= '1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ack_reg     <= ack_next;
            rdata_reg   <= rdata_next;
            addr_reg    <= addr_next;
            data_o_reg  <= data_o_next;
            data_oe_reg <= data_oe_next;
            ce_n_reg    <= ce_n_next;
            oe_n_reg    <= oe_n_next;
            we_n_reg    <= we_n_next;
            be_n_reg    <= be_n_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        ack_next     = 1'b0;
        rdata_next   = rdata_reg;
        addr_next    = addr_reg;
        data_o_next  = data_o_reg;
        data_oe_next = data_oe_reg;
        ce_n_next    = ce_n_reg;
        oe_n_next    = oe_n_reg;
        we_n_next    = we_n_reg;
        be_n_next    = be_n_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    addr_next = bus.addr;
                    ce_n_next = 1'b0;
                    if (bus.we) begin
                        data_o_next  = bus.wdata;
                        be_n_next    = ~bus.be;
                        data_oe_next = 1'b1;
                        oe_n_next    = 1'b1;
                        we_n_next    = 1'b1;
                        ack_next     = POSTED_WRITE;
                        state_next   = WR_SETUP;
                    end else begin
                        oe_n_next  = 1'b0;
                        be_n_next  = '0;
                        cnt_next   = RD_LOAD;
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (cnt_reg == '0) begin
                    rdata_next = ram_data_i;
                    ce_n_next  = 1'b1;
                    oe_n_next  = 1'b1;
                    be_n_next  = '1;
                    ack_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            WR_SETUP: begin
                we_n_next  = 1'b0;
                cnt_next   = WR_LOAD;
                state_next = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_reg == '0) begin
                    we_n_next  = 1'b1;
                    state_next = WR_HOLD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            WR_HOLD: begin
                ce_n_next    = 1'b1;
                data_oe_next = 1'b0;
                be_n_next    = '1;
                // A posted write was already acknowledged when it was accepted.
                ack_next     = !POSTED_WRITE;
                state_next   = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ack     = ack_reg;
    assign bus.rdata   = rdata_reg;
    assign ram_addr    = addr_reg;
    assign ram_data_o  = data_o_reg;
    assign ram_data_oe = data_oe_reg;
    assign ram_ce_n    = ce_n_reg;
    assign ram_oe_n    = oe_n_reg;
    assign ram_we_n    = we_n_reg;
    assign ram_be_n    = be_n_reg;

endmodule
